// File: rtl/store_buffer_ctrl.sv
// Posted-store buffer: forms lane-aligned write data and byte enables per store,
// queues up to DEPTH entries, and drains them in order over a req/gnt port.
module store_buffer_ctrl #(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         st_valid,
   output logic                         st_ready,
   input  logic [31:0]                  st_addr,
   input  logic [31:0]                  st_data,
   input  logic [2:0]                   st_funct3,
   output logic                         mem_req,
   input  logic                         mem_gnt,
   output logic [31:0]                  mem_addr,
   output logic [31:0]                  mem_wdata,
   output logic [3:0]                   mem_be,
   input  logic [31:0]                  ld_addr,
   output logic                         ld_hazard,
   input  logic                         flush_req,
   output logic                         flush_done,
   output logic                         misalign_err,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         idle
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   state_t           state, state_next;
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count_q, count_next;
   logic [DEPTH-1:0] valid_q, valid_next;
   logic [29:0]      addr_mem [DEPTH];
   logic [31:0]      data_mem [DEPTH];
   logic [3:0]       be_mem   [DEPTH];

   logic        full, accept, legal, push, pop, done_next;
   logic [1:0]  a;
   logic [31:0] lane_data;
   logic [3:0]  lane_be;

   // Both ports use valid/ready: a transfer happens on a rising edge where the
   // source's valid (st_valid / mem_req) and the sink's ready (st_ready / mem_gnt)
   // are both high; the source holds its payload stable until that edge.
   assign a          = st_addr[1:0];
   assign full       = (count_q == CW'(DEPTH));
   assign st_ready   = !full && (state == RUN);
   assign accept     = st_valid && st_ready;
   assign push       = accept && legal;
   assign mem_req    = (count_q != '0);
   assign pop        = mem_req && mem_gnt;
   assign count      = count_q;
   assign idle       = (count_q == '0) && (state == RUN);
   assign count_next = count_q + CW'(push) - CW'(pop);

   // Payload is forced to zero while empty so stale entries never show on the port.
   assign mem_addr  = mem_req ? {addr_mem[rd_ptr], 2'b00} : '0;
   assign mem_wdata = mem_req ? data_mem[rd_ptr] : '0;
   assign mem_be    = mem_req ? be_mem[rd_ptr] : '0;

   always_comb begin
      legal     = 1'b0;
      lane_data = st_data;
      lane_be   = 4'b0000;
      case (st_funct3)
         3'b000: begin
            legal     = 1'b1;
            lane_data = {4{st_data[7:0]}};
            lane_be   = 4'b0001 << a;
         end
         3'b001: begin
            legal     = !a[0];
            lane_data = {2{st_data[15:0]}};
            lane_be   = a[1] ? 4'b1100 : 4'b0011;
         end
         3'b010: begin
            legal     = (a == 2'b00);
            lane_data = st_data;
            lane_be   = 4'b1111;
         end
         default: legal = 1'b0;
      endcase
   end

   // Push and pop never target the same slot: a push needs a free slot, a pop a full one.
   always_comb begin
      valid_next = valid_q;
      if (pop)  valid_next[rd_ptr] = 1'b0;
      if (push) valid_next[wr_ptr] = 1'b1;
   end

   always_comb begin
      ld_hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (addr_mem[i] == ld_addr[31:2])) ld_hazard = 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      done_next  = 1'b0;
      case (state)
         RUN: begin
            if (flush_req) begin
               if (count_next == '0) done_next = 1'b1;
               else                  state_next = FLUSH;
            end
         end
         FLUSH: begin
            if (count_next == '0) begin
               state_next = RUN;
               done_next  = 1'b1;
            end
         end
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= RUN;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count_q      <= '0;
         valid_q      <= '0;
         flush_done   <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         state        <= state_next;
         count_q      <= count_next;
         valid_q      <= valid_next;
         flush_done   <= done_next;
         misalign_err <= accept && !legal;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr] <= st_addr[31:2];
         data_mem[wr_ptr] <= lane_data;
         be_mem[wr_ptr]   <= lane_be;
      end
   end

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Bench for store_buffer_ctrl: directed scenarios plus random traffic, checked
// against a transaction-level model of the pending-store queue.
module tb_store_buffer_ctrl;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk;
   logic          rst_n;
   logic          st_valid;
   logic          st_ready;
   logic [31:0]   st_addr;
   logic [31:0]   st_data;
   logic [2:0]    st_funct3;
   logic          mem_req;
   logic          mem_gnt;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_be;
   logic [31:0]   ld_addr;
   logic          ld_hazard;
   logic          flush_req;
   logic          flush_done;
   logic          misalign_err;
   logic [CW-1:0] count;
   logic          idle;

   store_buffer_ctrl #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .st_valid(st_valid), .st_ready(st_ready),
      .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
      .mem_req(mem_req), .mem_gnt(mem_gnt),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .ld_addr(ld_addr), .ld_hazard(ld_hazard),
      .flush_req(flush_req), .flush_done(flush_done),
      .misalign_err(misalign_err), .count(count), .idle(idle)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model / scoreboard state ----------------
   logic [67:0] exp_q[$];          // {word addr (32b), wdata, be}
   logic [67:0] head;
   int          n_cmp = 0;
   int          n_err = 0;
   bit          chk_en = 0;
   bit          model_ready = 1;
   bit          flush_pending = 0;
   bit          err_exp = 0;
   int          gnt_mode = 0;       // 0 = held by main, 1 = random, 2 = toggling
   bit          ld_rand = 0;

   int          m_a;
   bit          m_ok;
   logic [31:0] m_wd;
   logic [3:0]  m_be;

   int          sz;
   bit          e_ready, e_done, e_hz;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference model: stores accepted on an edge are turned into expected writes.
   initial forever begin
      @(posedge clk);
      if (chk_en && rst_n) begin
         err_exp = 0;
         if (st_valid && model_ready) begin
            m_a  = int'(st_addr[1:0]);
            m_ok = 1;
            m_wd = st_data;
            m_be = 4'hF;
            case (st_funct3)
               3'd0: begin
                  m_wd = {24'd0, st_data[7:0]} * 32'h0101_0101;
                  m_be = 4'(1 << m_a);
               end
               3'd1: begin
                  m_ok = (m_a % 2 == 0);
                  m_wd = {16'd0, st_data[15:0]} * 32'h0001_0001;
                  m_be = 4'(3 << m_a);
               end
               3'd2: m_ok = (m_a == 0);
               default: m_ok = 0;
            endcase
            if (m_ok) exp_q.push_back({st_addr[31:2], 2'b00, m_wd, m_be});
            else      err_exp = 1;
         end
         if (flush_req && !flush_pending) flush_pending = 1;
      end
   end

   // Monitor: compares every observable output mid-cycle; pops on a granted request.
   initial forever begin
      @(negedge clk);
      if (chk_en && rst_n) begin
         sz      = exp_q.size();
         e_ready = (sz < DEPTH) && !(flush_pending && sz != 0);
         e_done  = flush_pending && (sz == 0);
         e_hz    = 0;
         foreach (exp_q[i]) if (exp_q[i][67:38] == ld_addr[31:2]) e_hz = 1;
         chk("count", 32'(count), sz);
         chk("mem_req", mem_req, sz != 0);
         chk("st_ready", st_ready, e_ready);
         chk("idle", idle, sz == 0);
         chk("ld_hazard", ld_hazard, e_hz);
         chk("misalign_err", misalign_err, err_exp);
         chk("flush_done", flush_done, e_done);
         if (sz != 0) begin
            head = exp_q[0];
            chk("mem_addr", mem_addr, head[67:36]);
            chk("mem_wdata", mem_wdata, head[35:4]);
            chk("mem_be", 32'(mem_be), 32'(head[3:0]));
            if (mem_req && mem_gnt) void'(exp_q.pop_front());
         end
         model_ready = e_ready;
         if (e_done) flush_pending = 0;
      end
   end

   // Background driver for grant patterns and random load addresses.
   initial forever begin
      @(posedge clk);
      #1;
      if (gnt_mode == 1)      mem_gnt = 1'($urandom_range(0, 1));
      else if (gnt_mode == 2) mem_gnt = !mem_gnt;
      if (ld_rand) ld_addr = 32'h1000 + 32'($urandom_range(0, 31));
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
      int  n;
      bit  acc;
      n = 0;
      st_valid  = 1;
      st_addr   = a;
      st_data   = d;
      st_funct3 = f;
      do begin
         acc = st_ready;
         cyc();
         n++;
      end while (!acc && n < 200);
      if (!acc) chk("send_timeout", 0, 1);
      st_valid = 0;
   endtask

   task automatic flush_pulse();
      flush_req = 1;
      cyc();
      flush_req = 0;
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 300; i++) begin
         if (exp_q.size() == 0) break;
         cyc();
      end
      chk("drain_timeout", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      chk_en = 0;
      rst_n  = 0;
      exp_q.delete();
      flush_pending = 0;
      err_exp       = 0;
      model_ready   = 1;
      #1;
      chk("rst_count", 32'(count), 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_be", 32'(mem_be), 0);
      chk("rst_st_ready", st_ready, 1);
      chk("rst_idle", idle, 1);
      chk("rst_flush_done", flush_done, 0);
      chk("rst_misalign_err", misalign_err, 0);
      cyc();
      cyc();
      rst_n  = 1;
      chk_en = 1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit seen;
      int r;
      logic [2:0] f3;
      rst_n = 1; st_valid = 0; st_addr = 0; st_data = 0; st_funct3 = 0;
      mem_gnt = 0; ld_addr = 0; flush_req = 0;
      cyc();
      do_reset();

      // SB to the top lane, granted immediately
      mem_gnt = 1;
      send(32'h1003, 32'h0000_00A5, 3'b000);
      @(negedge clk);
      chk("sb_req", mem_req, 1);
      chk("sb_addr", mem_addr, 32'h1000);
      chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
      chk("sb_be", 32'(mem_be), 32'b1000);
      cyc(); cyc();
      @(negedge clk);
      chk("sb_count0", 32'(count), 0);
      chk("sb_idle", idle, 1);
      cyc();

      // SH then SW under a stalled grant: head payload must hold
      mem_gnt = 0;
      send(32'h2002, 32'h1234_BEEF, 3'b001);
      send(32'h2004, 32'hCAFE_F00D, 3'b010);
      cyc();
      @(negedge clk);
      chk("sh_hold_addr", mem_addr, 32'h2000);
      chk("sh_hold_wdata", mem_wdata, 32'hBEEF_BEEF);
      chk("sh_hold_be", 32'(mem_be), 32'b1100);
      cyc();
      mem_gnt = 1;
      wait_empty();

      // Fill to full, single grant frees one slot, then wrap several times
      mem_gnt = 0;
      for (int i = 0; i < DEPTH; i++) send(32'h4000 + 32'(4 * i), $urandom, 3'b010);
      @(negedge clk);
      chk("full_ready", st_ready, 0);
      chk("full_count", 32'(count), DEPTH);
      cyc();
      mem_gnt = 1;
      cyc();
      mem_gnt = 0;
      @(negedge clk);
      chk("pop1_count", 32'(count), DEPTH - 1);
      chk("pop1_ready", st_ready, 1);
      cyc();
      mem_gnt = 1;
      for (int i = 0; i < 3 * DEPTH; i++) send(32'h5000 + 32'(4 * i), $urandom, 3'b010);
      wait_empty();

      // Rejected stores: misaligned SW and an illegal width
      send(32'h3001, 32'h1111_2222, 3'b010);
      @(negedge clk);
      chk("mis_sw_err", misalign_err, 1);
      chk("mis_sw_req", mem_req, 0);
      cyc();
      send(32'h3004, 32'h3333_4444, 3'b011);
      @(negedge clk);
      chk("mis_f3_err", misalign_err, 1);
      chk("mis_f3_count", 32'(count), 0);
      cyc();
      @(negedge clk);
      chk("mis_once", misalign_err, 0);
      cyc();

      // Load hazard against the second of three pending entries
      mem_gnt = 0;
      send(32'h1000, 32'hAAAA_0000, 3'b010);
      send(32'h1004, 32'hAAAA_0001, 3'b010);
      send(32'h1008, 32'hAAAA_0002, 3'b010);
      ld_addr = 32'h1006;
      @(negedge clk);
      chk("hz_hit", ld_hazard, 1);
      cyc();
      mem_gnt = 1;
      cyc();
      mem_gnt = 0;
      @(negedge clk);
      chk("hz_still", ld_hazard, 1);
      cyc();
      mem_gnt = 1;
      cyc();
      mem_gnt = 0;
      @(negedge clk);
      chk("hz_clear", ld_hazard, 0);
      cyc();
      mem_gnt = 1;
      wait_empty();

      // Flush with two entries and a grant every other cycle; repeat pulse is ignored
      mem_gnt = 0;
      send(32'h6000, 32'h0BAD_F00D, 3'b010);
      send(32'h6006, 32'h0000_7777, 3'b001);
      flush_pulse();
      gnt_mode = 2;
      cyc();
      flush_pulse();
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (flush_done) begin
            seen = 1;
            break;
         end
         cyc();
      end
      chk("flush_done_seen", seen, 1);
      cyc();
      gnt_mode = 0;
      mem_gnt  = 1;
      wait_empty();
      flush_pulse();
      @(negedge clk);
      chk("flush_empty_done", flush_done, 1);
      cyc();

      // Reset in the middle of a flush drops everything
      mem_gnt = 0;
      send(32'h7000, 32'h1, 3'b010);
      send(32'h7004, 32'h2, 3'b010);
      send(32'h7008, 32'h3, 3'b010);
      flush_pulse();
      cyc();
      do_reset();

      // Random traffic
      gnt_mode = 1;
      ld_rand  = 1;
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 15);
         if (r < 5)       f3 = 3'b000;
         else if (r < 10) f3 = 3'b001;
         else if (r < 14) f3 = 3'b010;
         else             f3 = 3'($urandom_range(3, 7));
         send(32'h1000 + 32'($urandom_range(0, 31)), $urandom, f3);
         if ($urandom_range(0, 3) == 0) cyc();
         if ($urandom_range(0, 39) == 0) flush_pulse();
      end
      gnt_mode = 0;
      ld_rand  = 0;
      mem_gnt  = 1;
      wait_empty();
      cyc(); cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      n_err++;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
